// File: rtl/a2d_chnl_scanner.sv
// Round-robin conversion scanner sitting in front of the SPI A2D interface.
// Optional 4-sample averaging per channel is built when A2D_SCAN_AVG4_EN is defined.
module a2d_chnl_scanner #(
    parameter int NUM_CH   = 8,
    parameter int SCAN_GAP = 1000,
    parameter int TIMEOUT  = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [15:0] res,
    input  logic [2:0]  rd_chnl,
    output logic [11:0] rd_data,
    output logic [7:0]  valid,
    output logic        scan_done,
    output logic        err,
    input  logic        clr_err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((SCAN_GAP > 0) ? SCAN_GAP - 1 : 0);
    localparam logic [2:0]    LAST_IDX = 3'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_NEXT,
        S_GAP
    } state_t;

    state_t          state, state_d;
    logic [2:0]      index, index_d;
    logic [TW-1:0]   tmo_cnt;
    logic [GW-1:0]   gap_cnt;
    logic [11:0]     regs [8];
    logic [11:0]     store_val;
    logic            capture, store, tmo_hit, last;

    assign capture = (state == S_WAIT) && cnv_cmplt;
    // The result that arrives on the final allowed WAIT cycle still counts.
    assign tmo_hit = (state == S_WAIT) && !cnv_cmplt && (tmo_cnt == TMO_LAST);
    assign last    = (index == LAST_IDX);

`ifdef A2D_SCAN_AVG4_EN
    logic [1:0]  avg_cnt;
    logic [13:0] acc, acc_sum;
    logic        unused_res;

    assign acc_sum    = acc + {2'b00, res[11:0]};
    assign store      = capture && (avg_cnt == 2'd3);
    assign store_val  = acc_sum[13:2];
    assign unused_res = ^res[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avg_cnt <= '0;
            acc     <= '0;
        end else if (state == S_IDLE || state == S_NEXT || tmo_hit) begin
            avg_cnt <= '0;
            acc     <= '0;
        end else if (capture) begin
            avg_cnt <= avg_cnt + 2'd1;
            acc     <= acc_sum;
        end
    end
`else
    logic unused_res;

    assign store      = capture;
    assign store_val  = res[11:0];
    assign unused_res = ^res[15:12];
`endif

    always_comb begin
        state_d = state;
        index_d = index;
        case (state)
            S_IDLE: begin
                index_d = '0;
                if (en) state_d = S_START;
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (store || tmo_hit) state_d = S_NEXT;
                else if (capture)     state_d = S_START;
            end
            S_NEXT: begin
                index_d = last ? 3'd0 : index + 3'd1;
                if (!en)                       state_d = S_IDLE;
                else if (last && SCAN_GAP > 0) state_d = S_GAP;
                else                           state_d = S_START;
            end
            S_GAP: begin
                if (!en)                      state_d = S_IDLE;
                else if (gap_cnt == GAP_LAST) state_d = S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            index <= '0;
        end else begin
            state <= state_d;
            index <= index_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt   <= '0;
            gap_cnt   <= '0;
            strt_cnv  <= 1'b0;
            chnnl     <= '0;
            scan_done <= 1'b0;
            err       <= 1'b0;
            valid     <= '0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (state == S_START)                  tmo_cnt <= '0;
            else if (state == S_WAIT && !cnv_cmplt) tmo_cnt <= tmo_cnt + 1'b1;

            if (state == S_GAP) gap_cnt <= gap_cnt + 1'b1;
            else                gap_cnt <= '0;

            strt_cnv <= (state_d == S_START);
            if (state_d == S_START) chnnl <= index_d;
            scan_done <= (state == S_NEXT) && last;

            if (tmo_hit)      err <= 1'b1;
            else if (clr_err) err <= 1'b0;

            if (store) begin
                regs[index]  <= store_val;
                valid[index] <= 1'b1;
            end
        end
    end

    // Entries at or above NUM_CH are never written, so they read back as zero.
    assign rd_data = regs[rd_chnl];

endmodule

// File: tb/tb_a2d_chnl_scanner.sv
// Directed bench for a2d_chnl_scanner (default build) with a small A2D responder
// model driven inline and a scoreboard of expected captured results.
module tb_a2d_chnl_scanner;

    localparam int NUM_CH   = 8;
    localparam int SCAN_GAP = 10;
    localparam int TIMEOUT  = 16;

    logic        clk = 1'b0;
    logic        rst_n, en, strt_cnv, cnv_cmplt, scan_done, err, clr_err;
    logic [2:0]  chnnl, rd_chnl;
    logic [15:0] res;
    logic [11:0] rd_data;
    logic [7:0]  valid;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [11:0] exp_q [$];
    logic [11:0] model_regs [8];

    always #5 clk = ~clk;

    a2d_chnl_scanner #(
        .NUM_CH(NUM_CH), .SCAN_GAP(SCAN_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .strt_cnv(strt_cnv), .chnnl(chnnl),
        .cnv_cmplt(cnv_cmplt), .res(res), .rd_chnl(rd_chnl), .rd_data(rd_data),
        .valid(valid), .scan_done(scan_done), .err(err), .clr_err(clr_err)
    );

    initial begin
        #5_000_000;
        $display("FAIL watchdog cycles=%0d limit reached", cyc);
        $fatal(1, "bench watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic wait_strt(output int t);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (strt_cnv !== 1'b1 && n < 2000);
        check("strt_wait", 32'(strt_cnv), 32'd1);
        t = cyc;
    endtask

    // Called at the negedge of the strt_cnv cycle; conv_t idle cycles separate
    // the start pulse from the cnv_cmplt cycle.
    task automatic convert_from_strt(input logic [2:0] ch, input logic [15:0] r, input int conv_t);
        repeat (conv_t + 1) tick();
        cnv_cmplt = 1'b1;
        res = r;
        exp_q.push_back(r[11:0]);
        model_regs[ch] = r[11:0];
        tick();
        cnv_cmplt = 1'b0;
        res = 16'($urandom);
        rd_chnl = ch;
        #1;
        check("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
        check("valid_bit", 32'(valid[ch]), 32'd1);
    endtask

    task automatic check_all_regs();
        for (int i = 0; i < 8; i++) begin
            rd_chnl = 3'(i);
            #1;
            check("rd_all", 32'(rd_data), 32'(model_regs[i]));
        end
    endtask

    initial begin
        int t, t_prev, ct, prev_ct, n;
        logic [15:0] r;

        rst_n = 1'b0; en = 1'b0; cnv_cmplt = 1'b0; res = '0; rd_chnl = '0; clr_err = 1'b0;
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        t_prev = 0;
        repeat (3) tick();
        check("rst_strt", 32'(strt_cnv), 32'd0);
        check("rst_chnnl", 32'(chnnl), 32'd0);
        check("rst_scan_done", 32'(scan_done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        tick();
        check_all_regs();

        // Scan 1: fixed conversion time, res = 0x0ABC + channel.
        en = 1'b1;
        for (int ch = 0; ch < 8; ch++) begin
            wait_strt(t);
            check("s1_chnnl", 32'(chnnl), 32'(ch));
            if (ch > 0) check("s1_gap", 32'(t - t_prev), 32'd13);
            t_prev = t;
            convert_from_strt(3'(ch), 16'h0ABC + 16'(ch), 10);
        end
        tick();
        check("s1_scan_done", 32'(scan_done), 32'd1);
        check("s1_valid", 32'(valid), 32'hFF);
        rd_chnl = 3'd5;
        #1;
        check("s1_rd5", 32'(rd_data), 32'hAC1);
        tick();
        check("s1_scan_done_low", 32'(scan_done), 32'd0);

        // Scan 2: random conversion times and values, inter-scan gap.
        prev_ct = 10;
        for (int ch = 0; ch < 8; ch++) begin
            wait_strt(t);
            check("s2_chnnl", 32'(chnnl), 32'(ch));
            if (ch == 0) check("s2_scan_gap", 32'(t - t_prev), 32'(prev_ct + 3 + SCAN_GAP));
            else         check("s2_gap", 32'(t - t_prev), 32'(prev_ct + 3));
            t_prev = t;
            ct = $urandom_range(1, 12);
            r = 16'($urandom_range(0, 65535));
            convert_from_strt(3'(ch), r, ct);
            prev_ct = ct;
        end
        tick();
        check("s2_scan_done", 32'(scan_done), 32'd1);

        // Stray cnv_cmplt in GAP, then in IDLE.
        cnv_cmplt = 1'b1; res = 16'h0FFF;
        tick();
        cnv_cmplt = 1'b0;
        check_all_regs();
        en = 1'b0;
        tick();
        cnv_cmplt = 1'b1; res = 16'h0EEE;
        tick();
        cnv_cmplt = 1'b0;
        n = 0;
        repeat (30) begin
            tick();
            if (strt_cnv === 1'b1) n++;
        end
        check("idle_no_strt", 32'(n), 32'd0);
        check_all_regs();
        check("idle_valid", 32'(valid), 32'hFF);

        // en dropped mid-WAIT: result still stored, then no more starts.
        en = 1'b1;
        wait_strt(t);
        check("endrop_chnnl", 32'(chnnl), 32'd0);
        tick();
        tick();
        en = 1'b0;
        repeat (4) tick();
        cnv_cmplt = 1'b1; res = 16'h0123; model_regs[0] = 12'h123;
        tick();
        cnv_cmplt = 1'b0;
        rd_chnl = 3'd0;
        #1;
        check("endrop_rd0", 32'(rd_data), 32'h123);
        n = 0;
        repeat (40) begin
            tick();
            if (strt_cnv === 1'b1) n++;
        end
        check("endrop_no_strt", 32'(n), 32'd0);
        check("endrop_valid", 32'(valid), 32'hFF);

        // Reset asserted during the WAIT of channel 1.
        en = 1'b1;
        wait_strt(t);
        convert_from_strt(3'd0, 16'h0456, 3);
        wait_strt(t);
        check("prerst_chnnl", 32'(chnnl), 32'd1);
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) model_regs[i] = '0;
        check("arst_strt", 32'(strt_cnv), 32'd0);
        check("arst_chnnl", 32'(chnnl), 32'd0);
        check("arst_valid", 32'(valid), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        check_all_regs();
        tick();
        rst_n = 1'b1;
        wait_strt(t);
        check("postrst_chnnl", 32'(chnnl), 32'd0);
        check("postrst_valid", 32'(valid), 32'd0);
        t_prev = t;

        // Timeout scan: channel 3 never answers.
        for (int ch = 0; ch < 3; ch++) begin
            if (ch > 0) begin
                wait_strt(t);
                check("to_chnnl", 32'(chnnl), 32'(ch));
                check("to_gap", 32'(t - t_prev), 32'd8);
                t_prev = t;
            end
            convert_from_strt(3'(ch), 16'($urandom_range(0, 65535)), 5);
        end
        wait_strt(t);
        check("to_ch3", 32'(chnnl), 32'd3);
        check("to_gap3", 32'(t - t_prev), 32'd8);
        n = 0;
        do begin
            tick();
            n++;
        end while (err !== 1'b1 && n < 100);
        check("err_latency", 32'(cyc - t), 32'd16);
        check("to_valid", 32'(valid), 32'h07);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("clr_err", 32'(err), 32'd0);
        check("to_strt4", 32'(strt_cnv), 32'd1);
        check("to_chnnl4", 32'(chnnl), 32'd4);
        check("to_gap4", 32'(cyc - t), 32'd17);
        t_prev = cyc;
        convert_from_strt(3'd4, 16'($urandom_range(0, 65535)), 5);
        for (int ch = 5; ch < 8; ch++) begin
            wait_strt(t);
            check("to_chnnl_tail", 32'(chnnl), 32'(ch));
            check("to_gap_tail", 32'(t - t_prev), 32'd8);
            t_prev = t;
            convert_from_strt(3'(ch), 16'($urandom_range(0, 65535)), 5);
        end
        tick();
        check("to_scan_done", 32'(scan_done), 32'd1);
        check("to_valid_end", 32'(valid), 32'hF7);
        check_all_regs();

        // Completion on the last allowed WAIT cycle beats the watchdog.
        wait_strt(t);
        check("edge_chnnl", 32'(chnnl), 32'd0);
        check("edge_gap", 32'(t - t_prev), 32'(5 + 3 + SCAN_GAP));
        convert_from_strt(3'd0, 16'h0777, 14);
        check("edge_no_err", 32'(err), 32'd0);
        check("edge_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
